// File: rtl/hc21_ste_pkg.sv
// Shared definitions for the HC21 STE bus slave: command codes, bus widths
// and the transfer state machine encoding.
package hc21_ste_pkg;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 8;
    localparam int LOC_ADDR_W = 12;

    localparam logic [2:0] CM_MEM_RD = 3'b111;
    localparam logic [2:0] CM_MEM_WR = 3'b110;
    localparam logic [2:0] CM_IO_RD  = 3'b101;
    localparam logic [2:0] CM_IO_WR  = 3'b100;
    localparam logic [2:0] CM_VEC    = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ACCESS,
        ACK,
        ERR,
        IGNORE
    } ste_state_t;

endpackage

// File: rtl/hc21_sync2.sv
// Two-flop synchroniser for an active-low asynchronous strobe; resets to the
// inactive (high) level so no transfer is seen coming out of reset.
module hc21_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/hc21_ste_slave_interface.sv
// STE bus slave: decodes a strobed command/address, runs a local access with
// wait states and a timeout, and answers with DATACK_n or TFRERR_n.
module hc21_ste_slave_interface
    import hc21_ste_pkg::*;
#(
    parameter logic [ADDR_W-1:0]     MEM_BASE    = 20'hF0000,
    parameter int                    MEM_BITS    = 12,
    parameter logic [LOC_ADDR_W-1:0] IO_BASE     = 12'h200,
    parameter int                    IO_BITS     = 4,
    parameter int                    WAIT_STATES = 2,
    parameter int                    TIMEOUT     = 64,
    parameter logic [DATA_W-1:0]     VECTOR      = 8'hFF
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  busstb_n,
    input  logic [2:0]            cm,
    input  logic [ADDR_W-1:0]     adr,
    input  logic [DATA_W-1:0]     dat_in,
    output logic [DATA_W-1:0]     dat_out,
    output logic                  dat_oe,
    output logic                  datack_n,
    output logic                  tfrerr_n,
    output logic [LOC_ADDR_W-1:0] loc_addr,
    output logic                  loc_rd,
    output logic                  loc_wr,
    output logic [DATA_W-1:0]     loc_wdata,
    input  logic [DATA_W-1:0]     loc_rdata,
    input  logic                  loc_rdy,
    input  logic                  irq_pend
);

    localparam int MIN_ACCESS = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
    localparam int CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_ACCESS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [LOC_ADDR_W-1:0] MEM_MASK =
        LOC_ADDR_W'((ADDR_W'(1) << MEM_BITS) - ADDR_W'(1));
    localparam logic [LOC_ADDR_W-1:0] IO_MASK =
        LOC_ADDR_W'((LOC_ADDR_W'(1) << IO_BITS) - LOC_ADDR_W'(1));

    ste_state_t r_state;
    ste_state_t w_nextState;

    logic                  w_stbS;
    logic [2:0]            r_cm;
    logic [ADDR_W-1:0]     r_adr;
    logic [DATA_W-1:0]     r_din;
    logic                  r_irq;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_elapsed;

    logic                  w_isRead;
    logic                  w_memHit;
    logic                  w_ioHit;
    logic                  w_vecHit;
    logic [LOC_ADDR_W-1:0] w_memOff;
    logic [LOC_ADDR_W-1:0] w_ioOff;

    logic [DATA_W-1:0]     r_datOut, w_datOut;
    logic                  r_datOe, w_datOe;
    logic                  r_datackN, w_datackN;
    logic                  r_tfrerrN, w_tfrerrN;
    logic [LOC_ADDR_W-1:0] r_locAddr, w_locAddr;
    logic                  r_locRd, w_locRd;
    logic                  r_locWr, w_locWr;
    logic [DATA_W-1:0]     r_locWdata, w_locWdata;

    hc21_sync2 u_stbSync (
        .i_clk (sysclk),
        .i_rst (reset),
        .i_d   (busstb_n),
        .o_q   (w_stbS)
    );

    // Decode works on the values captured at strobe start, never the live bus.
    assign w_isRead = (r_cm == CM_MEM_RD) || (r_cm == CM_IO_RD);
    assign w_memHit = ((r_cm == CM_MEM_RD) || (r_cm == CM_MEM_WR)) &&
                      ((r_adr >> MEM_BITS) == (MEM_BASE >> MEM_BITS));
    assign w_ioHit  = ((r_cm == CM_IO_RD) || (r_cm == CM_IO_WR)) &&
                      ((r_adr[LOC_ADDR_W-1:0] >> IO_BITS) == (IO_BASE >> IO_BITS));
    assign w_vecHit = (r_cm == CM_VEC) && r_irq;
    assign w_memOff = r_adr[LOC_ADDR_W-1:0] & MEM_MASK;
    assign w_ioOff  = r_adr[LOC_ADDR_W-1:0] & IO_MASK;
    assign w_elapsed = r_cnt + CNT_W'(1);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cm    <= '0;
            r_adr   <= '0;
            r_din   <= '0;
            r_irq   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && !w_stbS) begin
                r_cm  <= cm;
                r_adr <= adr;
                r_din <= dat_in;
                r_irq <= irq_pend;
            end
            if (r_state == ACCESS && w_nextState == ACCESS)
                r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : w_elapsed;
            else
                r_cnt <= '0;
        end
    end

    // A rising strobe always wins; in ACCESS a ready beats a same-cycle timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (!w_stbS) w_nextState = DECODE;
            DECODE: begin
                if (w_stbS)                    w_nextState = IDLE;
                else if (w_memHit || w_ioHit)  w_nextState = ACCESS;
                else if (w_vecHit)             w_nextState = ACK;
                else                           w_nextState = IGNORE;
            end
            ACCESS: begin
                if (w_stbS)                               w_nextState = IDLE;
                else if (loc_rdy && w_elapsed >= CNT_MIN) w_nextState = ACK;
                else if (w_elapsed >= CNT_MAX)            w_nextState = ERR;
            end
            ACK, ERR, IGNORE: if (w_stbS) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        w_datackN  = 1'b1;
        w_tfrerrN  = 1'b1;
        w_datOe    = 1'b0;
        w_locRd    = 1'b0;
        w_locWr    = 1'b0;
        w_datOut   = r_datOut;
        w_locAddr  = r_locAddr;
        w_locWdata = r_locWdata;
        case (w_nextState)
            IDLE: begin
                w_datOut   = '0;
                w_locAddr  = '0;
                w_locWdata = '0;
            end
            ACCESS: begin
                w_locRd = w_isRead;
                w_locWr = !w_isRead;
                if (r_state == DECODE) begin
                    w_locAddr  = w_memHit ? w_memOff : w_ioOff;
                    w_locWdata = r_din;
                end
            end
            ACK: begin
                w_datackN = 1'b0;
                w_datOe   = w_isRead || (r_cm == CM_VEC);
                if (r_state == DECODE)
                    w_datOut = VECTOR;
                else if (r_state == ACCESS && w_isRead)
                    w_datOut = loc_rdata;
            end
            ERR: w_tfrerrN = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_datOut   <= '0;
            r_datOe    <= 1'b0;
            r_datackN  <= 1'b1;
            r_tfrerrN  <= 1'b1;
            r_locAddr  <= '0;
            r_locRd    <= 1'b0;
            r_locWr    <= 1'b0;
            r_locWdata <= '0;
        end else begin
            r_datOut   <= w_datOut;
            r_datOe    <= w_datOe;
            r_datackN  <= w_datackN;
            r_tfrerrN  <= w_tfrerrN;
            r_locAddr  <= w_locAddr;
            r_locRd    <= w_locRd;
            r_locWr    <= w_locWr;
            r_locWdata <= w_locWdata;
        end
    end

    assign dat_out   = r_datOut;
    assign dat_oe    = r_datOe;
    assign datack_n  = r_datackN;
    assign tfrerr_n  = r_tfrerrN;
    assign loc_addr  = r_locAddr;
    assign loc_rd    = r_locRd;
    assign loc_wr    = r_locWr;
    assign loc_wdata = r_locWdata;

endmodule

// File: tb/tb_hc21_ste_slave_interface.sv
// Self-checking bench for the HC21 STE slave: directed and random transfers
// compared against an address-window / cycle-count model of the bus protocol.
module tb_hc21_ste_slave_interface;

    localparam int WS = 2;
    localparam int TO = 64;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        busstb_n;
    logic [2:0]  cm;
    logic [19:0] adr;
    logic [7:0]  dat_in;
    logic [7:0]  dat_out;
    logic        dat_oe;
    logic        datack_n;
    logic        tfrerr_n;
    logic [11:0] loc_addr;
    logic        loc_rd;
    logic        loc_wr;
    logic [7:0]  loc_wdata;
    logic [7:0]  loc_rdata;
    logic        loc_rdy;
    logic        irq_pend;

    int total = 0;
    int bad   = 0;

    always #5 sysclk = ~sysclk;

    hc21_ste_slave_interface #(
        .WAIT_STATES (WS),
        .TIMEOUT     (TO)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .busstb_n  (busstb_n),
        .cm        (cm),
        .adr       (adr),
        .dat_in    (dat_in),
        .dat_out   (dat_out),
        .dat_oe    (dat_oe),
        .datack_n  (datack_n),
        .tfrerr_n  (tfrerr_n),
        .loc_addr  (loc_addr),
        .loc_rd    (loc_rd),
        .loc_wr    (loc_wr),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .loc_rdy   (loc_rdy),
        .irq_pend  (irq_pend)
    );

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    // Idle state both during and after reset.
    task automatic test_reset;
        reset = 1'b1; busstb_n = 1'b1; cm = '0; adr = '0; dat_in = '0;
        loc_rdata = '0; loc_rdy = 1'b0; irq_pend = 1'b0;
        tick; tick;
        total++;
        if ({datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr} !== 5'b11000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 11000", {datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr});
        end
        total++;
        if (dat_out !== 8'h00 || loc_addr !== 12'h000 || loc_wdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_data: got dat_out=%h loc_addr=%h loc_wdata=%h want 0", dat_out, loc_addr, loc_wdata);
        end
        reset = 1'b0;
        tick; tick; tick;
        total++;
        if ({datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr} !== 5'b11000 || dat_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL post_reset: got %b dat_out=%h want 11000 00", {datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr}, dat_out);
        end
    endtask

    // One full strobe; expectations come from address windows and cycle counts.
    task automatic test_transfer(input string name, input logic [2:0] c, input logic [19:0] a,
                                 input logic [7:0] d, input logic irq, input int readyAt,
                                 input logic [7:0] rdata);
        bit isMem, isIo, isVec, isRd, memHit, ioHit, isLocal, expAck, expErr;
        int memOff, ioOff, minA, need, expLen, expAddr, limit, len;
        bit sawAck, sawErr, overlap, early, unstable, firstRd, released;
        logic [11:0] firstAddr;
        logic [7:0]  firstWdata, ackOut;
        logic        ackOe, errOe;

        isMem   = (c == 3'b111) || (c == 3'b110);
        isIo    = (c == 3'b101) || (c == 3'b100);
        isVec   = (c == 3'b011);
        isRd    = (c == 3'b111) || (c == 3'b101);
        memOff  = int'(a) - 'hF0000;
        ioOff   = int'(a % 20'd4096) - 'h200;
        memHit  = isMem && memOff >= 0 && memOff < 4096;
        ioHit   = isIo && ioOff >= 0 && ioOff < 16;
        isLocal = memHit || ioHit;
        minA    = (WS < 1) ? 1 : WS;
        need    = (readyAt > minA) ? readyAt : minA;
        expAck  = (isLocal && need <= TO) || (isVec && irq);
        expErr  = isLocal && need > TO;
        expLen  = isLocal ? ((need > TO) ? TO : need) : 0;
        expAddr = memHit ? memOff : (ioHit ? ioOff : 0);

        len = 0; sawAck = 0; sawErr = 0; overlap = 0; early = 0; unstable = 0;
        firstRd = 0; firstAddr = '0; firstWdata = '0; ackOut = '0; ackOe = 0; errOe = 0;
        cm = c; adr = a; dat_in = d; irq_pend = irq; loc_rdata = rdata; loc_rdy = 1'b0;
        busstb_n = 1'b0;
        limit = (expAck || expErr) ? TO + 20 : 14;
        for (int n = 0; n < limit && !sawAck && !sawErr; n++) begin
            tick;
            if (loc_rd || loc_wr) begin
                len++;
                if (len == 1) begin
                    firstAddr = loc_addr; firstRd = loc_rd; firstWdata = loc_wdata;
                end else if (loc_addr !== firstAddr || loc_wdata !== firstWdata) begin
                    unstable = 1;
                end
                loc_rdy = (len >= readyAt);
            end else begin
                loc_rdy = 1'b0;
            end
            if (datack_n === 1'b0 && tfrerr_n === 1'b0) overlap = 1;
            if (datack_n === 1'b0) begin
                sawAck = 1; ackOut = dat_out; ackOe = dat_oe;
                if (loc_rd || loc_wr) early = 1;
            end
            if (tfrerr_n === 1'b0) begin
                sawErr = 1; errOe = dat_oe;
                if (loc_rd || loc_wr) early = 1;
            end
        end
        loc_rdy = 1'b0;

        total++;
        if (sawAck !== expAck) begin
            bad++; $display("[TB] FAIL %s ack: got %0b want %0b", name, sawAck, expAck);
        end
        total++;
        if (sawErr !== expErr) begin
            bad++; $display("[TB] FAIL %s err: got %0b want %0b", name, sawErr, expErr);
        end
        total++;
        if (len !== expLen) begin
            bad++; $display("[TB] FAIL %s strobe_len: got %0d want %0d", name, len, expLen);
        end
        total++;
        if (overlap || early || unstable) begin
            bad++; $display("[TB] FAIL %s protocol: got overlap=%0b early=%0b unstable=%0b want 0", name, overlap, early, unstable);
        end
        if (isLocal) begin
            total++;
            if (firstAddr !== 12'(expAddr) || firstRd !== isRd) begin
                bad++; $display("[TB] FAIL %s local: got addr=%h rd=%0b want addr=%h rd=%0b", name, firstAddr, firstRd, 12'(expAddr), isRd);
            end
            if (!isRd) begin
                total++;
                if (firstWdata !== d) begin
                    bad++; $display("[TB] FAIL %s wdata: got %h want %h", name, firstWdata, d);
                end
            end
        end
        if (expAck && sawAck) begin
            total++;
            if (ackOe !== (isRd || isVec)) begin
                bad++; $display("[TB] FAIL %s dat_oe: got %0b want %0b", name, ackOe, (isRd || isVec));
            end
            if (isRd || isVec) begin
                total++;
                if (ackOut !== (isVec ? 8'hFF : rdata)) begin
                    bad++; $display("[TB] FAIL %s dat_out: got %h want %h", name, ackOut, (isVec ? 8'hFF : rdata));
                end
            end
        end
        if (expErr && sawErr) begin
            total++;
            if (errOe !== 1'b0) begin
                bad++; $display("[TB] FAIL %s err_oe: got %0b want 0", name, errOe);
            end
        end
        if (sawAck || sawErr) begin
            tick; tick;
            total++;
            if ((sawAck && datack_n !== 1'b0) || (sawErr && tfrerr_n !== 1'b0)) begin
                bad++; $display("[TB] FAIL %s hold: got datack_n=%0b tfrerr_n=%0b want response held", name, datack_n, tfrerr_n);
            end
        end

        busstb_n = 1'b1;
        released = 0;
        for (int n = 0; n < 10 && !released; n++) begin
            tick;
            released = (datack_n === 1'b1 && tfrerr_n === 1'b1);
        end
        tick; tick;
        total++;
        if ({datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr} !== 5'b11000 || dat_out !== 8'h00 ||
            loc_addr !== 12'h000 || loc_wdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL %s release: got ctrl=%b dat_out=%h loc_addr=%h loc_wdata=%h want 11000 0 0 0",
                     name, {datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr}, dat_out, loc_addr, loc_wdata);
        end
    endtask

    task automatic test_directed;
        test_transfer("mem_read",   3'b111, 20'hF0123, 8'h00, 1'b0, 1,   8'h5A);
        test_transfer("io_write",   3'b100, 20'h00205, 8'hC3, 1'b0, 1,   8'h00);
        test_transfer("mem_miss",   3'b111, 20'hE0000, 8'h00, 1'b0, 1,   8'h77);
        test_transfer("timeout",    3'b111, 20'hF0010, 8'h00, 1'b0, 1000, 8'h11);
        test_transfer("rdy_at_to",  3'b110, 20'hF0FFF, 8'hA5, 1'b0, TO,  8'h00);
        test_transfer("vec_irq",    3'b011, 20'h00000, 8'h00, 1'b1, 1,   8'h00);
        test_transfer("vec_noirq",  3'b011, 20'h00000, 8'h00, 1'b0, 1,   8'h00);
        test_transfer("reserved",   3'b001, 20'hF0001, 8'h00, 1'b1, 1,   8'h00);
        test_transfer("io_edge",    3'b101, 20'h3420F, 8'h00, 1'b0, 4,   8'h9E);
        test_transfer("io_miss",    3'b101, 20'h00210, 8'h00, 1'b0, 1,   8'h9E);
    endtask

    task automatic test_random;
        logic [2:0]  c;
        logic [19:0] a;
        int          sel, rdyAt;
        for (int i = 0; i < 24; i++) begin
            c   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 3);
            if (sel <= 1)      a = 20'hF0000 | 20'($urandom_range(0, 4095));
            else if (sel == 2) a = {8'($urandom), 12'h200 | 12'($urandom_range(0, 31))};
            else               a = 20'($urandom);
            rdyAt = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(1, 5);
            test_transfer("random", c, a, 8'($urandom), 1'($urandom), rdyAt, 8'($urandom));
        end
    endtask

    // Abort during ACCESS, then reset while a later read is being acknowledged.
    task automatic test_abort_then_reset;
        bit seen, gotResp;
        cm = 3'b111; adr = 20'hF0040; irq_pend = 1'b0; loc_rdy = 1'b0; loc_rdata = 8'h66;
        busstb_n = 1'b0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick;
            seen = (loc_rd === 1'b1);
        end
        total++;
        if (!seen) begin
            bad++; $display("[TB] FAIL abort_start: got loc_rd=%0b want 1", loc_rd);
        end
        tick; tick; tick;
        busstb_n = 1'b1;
        gotResp = 0;
        for (int n = 0; n < 8; n++) begin
            tick;
            if (datack_n === 1'b0 || tfrerr_n === 1'b0) gotResp = 1;
        end
        total++;
        if (gotResp || loc_rd !== 1'b0) begin
            bad++; $display("[TB] FAIL abort: got resp=%0b loc_rd=%0b want 0 0", gotResp, loc_rd);
        end

        adr = 20'hF0FFF; loc_rdy = 1'b1; loc_rdata = 8'h3C;
        busstb_n = 1'b0;
        seen = 0;
        for (int n = 0; n < 14 && !seen; n++) begin
            tick;
            seen = (datack_n === 1'b0);
        end
        total++;
        if (!seen || dat_out !== 8'h3C || dat_oe !== 1'b1) begin
            bad++; $display("[TB] FAIL late_read: got ack=%0b dat_out=%h dat_oe=%0b want 1 3c 1", seen, dat_out, dat_oe);
        end
        reset = 1'b1;
        #1;
        total++;
        if (datack_n !== 1'b1 || dat_oe !== 1'b0 || dat_out !== 8'h00) begin
            bad++; $display("[TB] FAIL reset_in_ack: got datack_n=%0b dat_oe=%0b dat_out=%h want 1 0 00", datack_n, dat_oe, dat_out);
        end
        tick;
        busstb_n = 1'b1; loc_rdy = 1'b0;
        reset = 1'b0;
        tick; tick; tick; tick;
        total++;
        if ({datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr} !== 5'b11000) begin
            bad++; $display("[TB] FAIL after_reset: got %b want 11000", {datack_n, tfrerr_n, dat_oe, loc_rd, loc_wr});
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_abort_then_reset;
        test_random;
        test_transfer("back_to_back", 3'b110, 20'hF0ABC, 8'h3D, 1'b0, 2, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion want finish before 2000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hc21_ste_slave_interface.md
Name: hc21_ste_slave_interface

Overview:
- STE bus slave (responder) for HC21 peripheral cards; the counterpart of the CPU-side bus master that drives CM[2:0] and BUSSTB_n and waits on DATACK_n/TFRERR_n.
- Synchronises the strobe, decodes command and address, and runs a local read/write access with programmable wait states.
- Answers with DATACK_n on success, or with TFRERR_n on timeout.
- Also answers vector-fetch cycles when a local interrupt is pending.

Parameters:
- MEM_BASE, 20'hF0000: base of the memory window; window size is 2**MEM_BITS.
- MEM_BITS, 12: memory window offset width.
- IO_BASE, 12'h200: base of the I/O window; window size is 2**IO_BITS.
- IO_BITS, 4: I/O window offset width.
- WAIT_STATES, 2: minimum cycles loc_rd/loc_wr are held before loc_rdy is sampled (0..15).
- TIMEOUT, 64: maximum cycles in ACCESS before TFRERR_n is raised.
- VECTOR, 8'hFF: byte returned on vector fetch.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- busstb_n  in  1  STE transfer strobe, asynchronous to sysclk
- cm  in  3  STE command lines
- adr  in  20  STE address
- dat_in  in  8  STE data, master to slave
- dat_out  out  8  STE data, slave to master
- dat_oe  out  1  STE data buffer drive enable
- datack_n  out  1  transfer acknowledge
- tfrerr_n  out  1  transfer error
- loc_addr  out  12  offset within the hit window, zero-extended
- loc_rd  out  1  local read strobe
- loc_wr  out  1  local write strobe
- loc_wdata  out  8  latched write data
- loc_rdata  in  8  local read data
- loc_rdy  in  1  local ready; tie high if unused
- irq_pend  in  1  local interrupt pending; enables vector-fetch response

Behaviour:
- Reset: asynchronous and active-high. While reset is high and after release, all outputs are in their idle state: datack_n=1, tfrerr_n=1, dat_oe=0, loc_rd=0, loc_wr=0, dat_out=0, loc_addr=0, loc_wdata=0, FSM=IDLE.
- Reset asserted mid-transfer releases every output immediately; no acknowledge is issued.
- busstb_n passes through a 2-flop synchroniser (stb_s). A transfer starts on the cycle stb_s first reads 0 in IDLE. On that cycle cm, adr and dat_in are latched; the STE setup time guarantees they are stable.
- Command decode, cm[2:0]:
  - 111 memory read; 110 memory write.
  - 101 I/O read; 100 I/O write. I/O decodes adr[11:0] only.
  - 011 vector fetch.
  - All other encodings are reserved and are ignored.
- Hit conditions:
  - memory: adr[19:MEM_BITS] == MEM_BASE[19:MEM_BITS].
  - I/O: adr[11:IO_BITS] == IO_BASE[11:IO_BITS].
  - vector fetch: irq_pend=1 at latch time.
- FSM:
  - IDLE -> DECODE on the strobe start.
  - DECODE, 1 cycle: on a hit go to ACCESS for memory/I/O, or straight to ACK with dat_out=VECTOR for vector fetch. On a miss or reserved command go to IGNORE.
  - ACCESS: loc_rd or loc_wr is held high, with loc_addr and loc_wdata stable. A wait counter counts WAIT_STATES cycles, then loc_rdy is sampled each cycle.
    - When loc_rdy=1: capture loc_rdata into dat_out on reads, drop the strobe, go to ACK.
    - Minimum time in ACCESS is max(WAIT_STATES,1) cycles.
  - ACK: datack_n=0; dat_oe=1 for reads and vector fetch. Held until stb_s=1, then everything is released the following cycle and the FSM returns to IDLE.
  - ERR: entered when the ACCESS cycle count reaches TIMEOUT. tfrerr_n=0 and local strobes are dropped; dat_oe stays 0. Held until stb_s=1, then IDLE.
  - IGNORE: no outputs asserted; wait for stb_s=1, then IDLE.
- Master abort: stb_s=1 while in DECODE or ACCESS drops local strobes and returns to IDLE without asserting datack_n or tfrerr_n.
- datack_n and tfrerr_n are never low at the same time. Neither is asserted before the local access completes.
- If loc_rdy=1 on the same cycle the timeout count is reached, loc_rdy wins and the FSM goes to ACK.
- Counters saturate and do not wrap. A new transfer is accepted only from IDLE, so back-to-back strobes need stb_s=1 for at least 1 cycle.
- Outputs are registered, with no combinational path from any input to any output.

Decomposition:
- Package hc21_ste_pkg holds:
  - CM_MEM_RD, CM_MEM_WR, CM_IO_RD, CM_IO_WR, CM_VEC constants;
  - the FSM state encoding (IDLE, DECODE, ACCESS, ACK, ERR, IGNORE);
  - the address width constants.
- One sub-module: hc21_sync2 (2-flop synchroniser, async reset to 1), reused for busstb_n.

Test Plan:
- Memory read, adr=F0123, WAIT_STATES=2, loc_rdy=1, loc_rdata=5A -> loc_addr=123 and loc_rd held 2 cycles; then datack_n=0 with dat_out=5A and dat_oe=1 until the strobe rises; then all outputs idle.
- I/O write, adr=00205, dat_in=C3 -> loc_wr high, loc_addr=005, loc_wdata=C3; then datack_n=0 with dat_oe=0.
- Memory read, adr=E0000 (miss) -> datack_n, tfrerr_n, loc_rd and dat_oe all stay inactive for the entire strobe.
- loc_rdy held 0 -> tfrerr_n=0 after exactly 64 cycles in ACCESS, loc_rd dropped, datack_n stays 1.
- Vector fetch, cm=011: with irq_pend=1 -> datack_n=0 and dat_out=FF; with irq_pend=0 -> ignored.
- Strobe released during ACCESS, then reset asserted during ACK of a later read -> no acknowledge on the abort; on reset, datack_n=1 and dat_oe=0 in the same cycle.
